// File: rtl/pol2rec_pkg.sv
// pol2rec_pkg: constants and types shared by the CORDIC polar/rectangular
// converters (pol2rec and rec2pol).
//   state_t  : controller FSM states
//   KINV     : 1/K CORDIC gain compensation factor, 0.16 fixed point
//   DEG90    : 90.0 degrees, Q16.16
//   DEG180   : 180.0 degrees, Q16.16
//   FRAC     : number of fractional bits of every fixed-point operand
package pol2rec_pkg;

  localparam int          FRAC   = 16;
  localparam logic [15:0] KINV   = 16'h9B74;
  localparam logic [31:0] DEG90  = 32'h005A_0000;
  localparam logic [31:0] DEG180 = 32'h00B4_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational table of atan(2^-i) in degrees, Q16.16,
// rounded to nearest. Entries past i=22 round to zero.
//   index : micro-rotation number i (0..31)
//   atan  : atan(2^-index) in degrees, Q16.16
module cordic_atan_rom
  import pol2rec_pkg::*;
(
  input  logic [4:0]  index,
  output logic [31:0] atan
);

  // angle lookup for the current micro-rotation
  always_comb begin
    case (index)
      5'd0:    atan = 32'h002D_0000;
      5'd1:    atan = 32'h001A_90A7;
      5'd2:    atan = 32'h000E_0947;
      5'd3:    atan = 32'h0007_2001;
      5'd4:    atan = 32'h0003_938B;
      5'd5:    atan = 32'h0001_CA38;
      5'd6:    atan = 32'h0000_E52A;
      5'd7:    atan = 32'h0000_7297;
      5'd8:    atan = 32'h0000_394C;
      5'd9:    atan = 32'h0000_1CA6;
      5'd10:   atan = 32'h0000_0E53;
      5'd11:   atan = 32'h0000_0729;
      5'd12:   atan = 32'h0000_0395;
      5'd13:   atan = 32'h0000_01CA;
      5'd14:   atan = 32'h0000_00E5;
      5'd15:   atan = 32'h0000_0073;
      5'd16:   atan = 32'h0000_0039;
      5'd17:   atan = 32'h0000_001D;
      5'd18:   atan = 32'h0000_000E;
      5'd19:   atan = 32'h0000_0007;
      5'd20:   atan = 32'h0000_0004;
      5'd21:   atan = 32'h0000_0002;
      5'd22:   atan = 32'h0000_0001;
      default: atan = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/pol2rec.sv
// pol2rec: iterative rotation-mode CORDIC, polar to rectangular.
// One micro-rotation per clock; done pulses NITER+2 edges after start.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   start : one-cycle pulse, captures mod/angle when idle
//   mod   : unsigned modulus, Q16.16
//   angle : signed angle in degrees, Q16.16, [-180.0, +180.0)
//   x, y  : signed mod*cos(angle), mod*sin(angle), Q17.16
//   busy  : conversion in progress
//   done  : one-cycle pulse, x/y updated in the same cycle
// Build option: define POL2REC_GAIN_COMP_EN to pre-scale mod by 1/K so the
// outputs are true mod*cos/sin; otherwise outputs carry the CORDIC gain K.
module pol2rec
  import pol2rec_pkg::*;
#(
  parameter int W     = 32,
  parameter int NITER = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [W-1:0]        mod,
  input  logic [W-1:0]        angle,
  output logic signed [W:0]   x,
  output logic signed [W:0]   y,
  output logic                busy,
  output logic                done
);

  // two guard MSBs absorb the CORDIC gain growth
  localparam int         IW   = W + 2;
  localparam logic [4:0] LAST = 5'(NITER - 1);

  state_t               state_r, state_s;
  logic [4:0]           cnt_r, cnt_s;
  logic signed [IW-1:0] xi_r, xi_s, yi_r, yi_s, zi_r, zi_s;
  logic signed [W:0]    x_r, x_s, y_r, y_s;
  logic                 busy_r, busy_s, done_r, done_s;

  logic [31:0]          atan_s;
  logic signed [IW-1:0] atan_ext_s, m_s, ang_s, deg90_s, xsh_s, ysh_s;

  cordic_atan_rom u_rom (
    .index (cnt_r),
    .atan  (atan_s)
  );

  assign atan_ext_s = IW'(atan_s);
  assign deg90_s    = IW'(DEG90);
  assign ang_s      = IW'(signed'(angle));
  assign xsh_s      = xi_r >>> cnt_r;
  assign ysh_s      = yi_r >>> cnt_r;

`ifdef POL2REC_GAIN_COMP_EN
  // m = (mod * KINV) >> FRAC, computed in the capture cycle
  assign m_s = IW'(({16'd0, mod} * {{W{1'b0}}, KINV}) >> FRAC);
`else
  assign m_s = IW'(mod);
`endif

  // next-state, datapath and output computation
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    xi_s    = xi_r;
    yi_s    = yi_r;
    zi_s    = zi_r;
    x_s     = x_r;
    y_s     = y_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          busy_s  = 1'b1;
          cnt_s   = 5'd0;
          state_s = ST_RUN;
          // fold |angle| > 90 into CORDIC convergence range by a quarter turn
          if (ang_s > deg90_s) begin
            xi_s = {IW{1'b0}};
            yi_s = m_s;
            zi_s = ang_s - deg90_s;
          end else if (ang_s < -deg90_s) begin
            xi_s = {IW{1'b0}};
            yi_s = -m_s;
            zi_s = ang_s + deg90_s;
          end else begin
            xi_s = m_s;
            yi_s = {IW{1'b0}};
            zi_s = ang_s;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (zi_r[IW-1] == 1'b0) begin
          xi_s = xi_r - ysh_s;
          yi_s = yi_r + xsh_s;
          zi_s = zi_r - atan_ext_s;
        end else begin
          xi_s = xi_r + ysh_s;
          yi_s = yi_r - xsh_s;
          zi_s = zi_r + atan_ext_s;
        end
        if (cnt_r == LAST) begin
          cnt_s   = 5'd0;
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end
      ST_DONE: begin
        x_s     = xi_r[W:0];
        y_s     = yi_r[W:0];
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      xi_r    <= {IW{1'b0}};
      yi_r    <= {IW{1'b0}};
      zi_r    <= {IW{1'b0}};
      x_r     <= {(W+1){1'b0}};
      y_r     <= {(W+1){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      xi_r    <= xi_s;
      yi_r    <= yi_s;
      zi_r    <= zi_s;
      x_r     <= x_s;
      y_r     <= y_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_pol2rec.sv
// tb_pol2rec: directed and random checks of pol2rec against a real-arithmetic
// reference (mod * gain * cos/sin of the angle).
module tb_pol2rec;

  localparam int  W     = 32;
  localparam int  NITER = 32;
  // fixed-point CORDIC with floor shifts drifts a few LSB in late iterations
  localparam real TOL   = 16.0;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [W-1:0]      mod;
  logic [W-1:0]      angle;
  logic signed [W:0] x;
  logic signed [W:0] y;
  logic              busy;
  logic              done;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  always #5 clock = ~clock;

  pol2rec #(.W(W), .NITER(NITER)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mod   (mod),
    .angle (angle),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  // expected output from the converter's definition in real arithmetic
  function automatic real model_out(input logic [W-1:0] m, input logic [W-1:0] a, input bit want_y);
    real    mr, ar, k, p, s;
    longint ml;
    int     ai;
    ml = longint'(m);
    mr = ml;
    k  = 1.0;
    p  = 1.0;
    for (int i = 0; i < NITER; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
`ifdef POL2REC_GAIN_COMP_EN
    s = $floor(mr * 39796.0 / 65536.0) * k;
`else
    s = mr * k;
`endif
    ai = int'(a);
    ar = ai;
    ar = ar / 65536.0 * 3.14159265358979 / 180.0;
    return want_y ? s * $sin(ar) : s * $cos(ar);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic signed [W:0] obs, input real exp, input real tol);
    longint lo;
    real    ro, err;
    logic   ok;
    lo  = longint'(obs);
    ro  = lo;
    err = ro - exp;
    ok  = (err <= tol && err >= -tol) ? 1'b1 : 1'b0;
    check_cnt++;
    assert (ok === 1'b1) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0.2f (+/-%0.0f)", tag, lo, exp, tol);
    end
  endtask

  // one full conversion: latency, busy, output hold and result checks
  task automatic convert(input logic [W-1:0] m, input logic [W-1:0] a, input string tag);
    int                n;
    bit                seen;
    logic signed [W:0] xp, yp;
    xp    = x;
    yp    = y;
    start = 1'b1;
    mod   = m;
    angle = a;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq({tag, " busy"}, 64'(busy), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < NITER + 10) begin
      @(posedge clock); #1;
      n++;
      if (n == NITER / 2) begin
        check_eq({tag, " hold"}, 64'({x, y}), 64'({xp, yp}));
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check_eq({tag, " latency"}, 64'(n), 64'(NITER + 1));
    check_eq({tag, " busy_end"}, 64'(busy), 64'd0);
    check_tol({tag, " x"}, x, model_out(m, a, 1'b0), TOL);
    check_tol({tag, " y"}, y, model_out(m, a, 1'b1), TOL);
  endtask

  initial begin
    int   ndone;
    int   ra;
    logic [W-1:0] rm;

    reset = 1'b1;
    start = 1'b0;
    mod   = 32'h0;
    angle = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check_tol("rst x", x, 0.0, 0.0);
    check_tol("rst y", y, 0.0, 0.0);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    convert(32'h0001_0000, 32'h0000_0000, "m1_a0");
    @(posedge clock); #1;
    check_eq("done_pulse", 64'(done), 64'd0);
    convert(32'h0001_0000, 32'h005A_0000, "m1_a90");
    convert(32'h0001_0000, 32'hFF4C_0000, "m1_am180");
    convert(32'h0002_0000, 32'h002D_0000, "m2_a45");
    convert(32'h0000_0000, 32'h0021_8000, "m0");
    check_tol("m0 x2", x, 0.0, 2.0);
    check_tol("m0 y2", y, 0.0, 2.0);
    convert(32'h0003_4000, 32'hFFA6_0000, "m3_am90");

    // start while busy must be ignored
    start = 1'b1;
    mod   = 32'h0003_0000;
    angle = 32'h001E_0000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    mod   = 32'h0007_0000;
    angle = 32'hFFC4_0000;
    @(posedge clock); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < NITER + 8; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) ndone++;
    end
    check_eq("ign ndone", 64'(ndone), 64'd1);
    check_tol("ign x", x, model_out(32'h0003_0000, 32'h001E_0000, 1'b0), TOL);
    check_tol("ign y", y, model_out(32'h0003_0000, 32'h001E_0000, 1'b1), TOL);

    // reset in the middle of a conversion
    start = 1'b1;
    mod   = 32'h0005_0000;
    angle = 32'h0014_0000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort done", 64'(done), 64'd0);
    check_tol("abort x", x, 0.0, 0.0);
    check_tol("abort y", y, 0.0, 0.0);
    ndone = 0;
    for (int i = 0; i < NITER + 5; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) ndone++;
    end
    check_eq("abort nodone", 64'(ndone), 64'd0);
    convert(32'h0001_8000, 32'h0087_0000, "after_rst");

    // random operands, mod up to 16.0, angle in [-180, 180)
    for (int t = 0; t < 20; t++) begin
      rm = 32'($urandom_range(0, 32'h0010_0000));
      ra = int'($urandom_range(0, 360 * 65536 - 1)) - 180 * 65536;
      convert(rm, 32'(ra), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
